mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, memory word-address width.
REQ-002 Parameter DATA_W, default 18, memory word width.
REQ-003 Port clk, in, 1, single clock; all state changes on rising edge.
REQ-004 Port rst, in, 1, reset; synchronous and active-high.
REQ-005 Port if_req / if_addr, in, 1 / ADDR_W, instruction-fetch read request and address; held until if_gnt.
REQ-006 Port if_gnt / if_rvalid, out, 1 / 1, fetch grant pulse / fetch read-data-valid pulse.
REQ-007 Port if_rdata, out, DATA_W, fetched word; held until the next fetch response.
REQ-008 Port d_req / d_we, in, 1 / 1, data-port request; d_we=1 write, 0 read; held until d_gnt.
REQ-009 Port d_addr / d_wdata, in, ADDR_W / DATA_W, data-port address and write data.
REQ-010 Port d_gnt / d_rvalid, out, 1 / 1, data grant pulse / data read-valid pulse.
REQ-011 Port d_rdata, out, DATA_W, data read word; held until the next data read response.
REQ-012 Port mem_addr / mem_wdata, out, ADDR_W / DATA_W, to memory address / DataIn.
REQ-013 Port mem_re / mem_we, out, 1 / 1, to memory re_en / wr_en.
REQ-014 Port mem_rdata, in, DATA_W, from memory DataOut; valid the cycle after mem_re.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPTURE; grants issued only in IDLE.
REQ-016 IDLE, cycle N: grant one requester combinationally (gnt high in N only); latch addr, wdata, we, and port id at end of N; go to ISSUE.
REQ-017 Only one requester: grant it. Both requesting: grant the port that lost the previous contested arbitration; the first contest after reset goes to data.
REQ-018 ISSUE, cycle N+1: mem_re=~we, mem_we=we, mem_addr/mem_wdata from latches; next state CAPTURE if read, IDLE if write.
REQ-019 mem_re and mem_we SHALL never be high together; both low in IDLE and CAPTURE.
REQ-020 CAPTURE, cycle N+2: load mem_rdata into the granted port's rdata register at end of N+2; go to IDLE.
REQ-021 rvalid of the granted port SHALL pulse high for exactly cycle N+3; reads have 3-cycle gnt-to-rvalid latency; writes produce no rvalid.
REQ-022 IDLE in N+3 SHALL accept a new request concurrently with the rvalid pulse: read throughput 1 per 3 cycles, write 1 per 2.
REQ-023 A request dropped before its grant is not served; no grant while not in IDLE.
REQ-024 Addresses pass unchanged at full ADDR_W; no range check.

Reset
REQ-025 On rst: state IDLE; mem_re, mem_we, all gnt and rvalid outputs 0; mem_addr, mem_wdata, if_rdata, d_rdata 0; contest flag set so data wins next.
REQ-026 rst mid-access: outstanding access dropped, no rvalid for it; mem_re/mem_we low from the first rst cycle, so reset-time memory preload is undisturbed.

Structure
REQ-027 Shared package rob_mem_pkg holds ADDR_W, DATA_W defaults and the FSM state encoding.
REQ-028 Single module; no sub-module.

Verification (bench instantiates Memory with its reset contents)
REQ-029 Fetch read addr 0 after reset -> if_gnt in N, mem_re in N+1, if_rvalid in N+3 with if_rdata=18'h08014.
REQ-030 Data read addr 20 -> d_rvalid in N+3, d_rdata=42; then read 21 granted in N+3 -> d_rdata=3 in N+6.
REQ-031 Data write 7 to addr 30, then read 30 -> mem_we one cycle, no d_rvalid; read returns 7.
REQ-032 if_req and d_req held together for 4 transactions -> grants alternate D,F,D,F; each rvalid goes to the correct port only.
REQ-033 rst asserted in CAPTURE of a read -> no rvalid, all outputs 0 next cycle, mem_re/mem_we low throughout rst.
REQ-034 Back-to-back writes to addrs 40,41 -> d_gnt spacing 2 cycles; mem_re never high with mem_we.

Source files
------------

// File: rtl/rob_mem_pkg.sv
// Shared widths and FSM encoding for the single-port memory arbiter.
package rob_mem_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one synchronous memory: grant in IDLE, read data valid 3 cycles later.
// Requesters hold req until gnt; contested grants alternate, data wins the first contest after reset.
module mem_arbiter
  import rob_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic              d_prio_q, d_prio_d;
  logic              if_rvalid_q, d_rvalid_q;
  logic              pick_d;

  // Data wins when alone, or when contested and it lost the previous contest.
  assign pick_d = d_req & (~if_req | d_prio_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    port_d   = port_q;
    d_prio_d = d_prio_q;
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          if_gnt  = ~pick_d;
          d_gnt   = pick_d;
          port_d  = pick_d ? PORT_D : PORT_IF;
          addr_d  = pick_d ? d_addr : if_addr;
          wdata_d = pick_d ? d_wdata : '0;
          we_d    = pick_d & d_we;
          if (if_req && d_req) d_prio_d = ~pick_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_re  = ~we_q;
        mem_we  = we_q;
        state_d = we_q ? IDLE : CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes are killed in the very first reset cycle so a memory preload is never disturbed.
    if (rst) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      mem_re = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      port_q      <= PORT_IF;
      d_prio_q    <= 1'b1;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      port_q      <= port_d;
      d_prio_q    <= d_prio_d;
      if_rvalid_q <= (state_q == CAPTURE) && (port_q == PORT_IF);
      d_rvalid_q  <= (state_q == CAPTURE) && (port_q == PORT_D);
      if (state_q == CAPTURE) begin
        if (port_q == PORT_D) d_rdata_q  <= mem_rdata;
        else                  if_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_rvalid = if_rvalid_q & ~rst;
  assign d_rvalid  = d_rvalid_q & ~rst;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter with a behavioural synchronous memory preloaded at time zero.
module tb_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_re, mem_we;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          is_d;
    logic [DW-1:0] data;
    int            when;
  } exp_t;
  exp_t sb[$];

  // Monitor: every rvalid must match the head of the scoreboard in port, data and cycle.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (if_rvalid || d_rvalid) begin
      chk("rvalid_exclusive", {31'd0, if_rvalid & d_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", {31'd0, d_rvalid}, {31'd0, ~d_rvalid});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_port", {31'd0, d_rvalid}, {31'd0, e.is_d});
        chk("rvalid_cycle", cyc, e.when);
        chk("rvalid_data", e.is_d ? d_rdata : if_rdata, e.data);
      end
    end
    if (mem_re || mem_we) chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
    if (mem_we) chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
    prev_we = mem_we;
  end

  task automatic xact(input logic is_d, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp, output int gcyc);
    logic got;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (is_d ? d_gnt : if_gnt) got = 1'b1;
    end
    chk("gnt_seen", {31'd0, got}, 32'd1);
    gcyc = cyc;
    chk("other_gnt", {31'd0, is_d ? if_gnt : d_gnt}, 32'd0);
    if (!we) sb.push_back('{is_d, exp, cyc + 3});
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("issue_re", {31'd0, mem_re}, {31'd0, ~we});
    chk("issue_we", {31'd0, mem_we}, {31'd0, we});
    chk("issue_addr", {19'd0, mem_addr}, {19'd0, addr});
    if (we) chk("issue_wdata", {14'd0, mem_wdata}, {14'd0, wd});
  endtask

  initial begin
    int g1, g2;
    logic got;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0] = 18'h08014; mem[20] = 18'd42; mem[21] = 18'd3;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {14'd0, mem_wdata}, 32'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    xact(1'b0, 1'b0, 13'd0, '0, 18'h08014, g1);
    xact(1'b1, 1'b0, 13'd20, '0, 18'd42, g1);
    xact(1'b1, 1'b0, 13'd21, '0, 18'd3, g2);
    chk("read_spacing", g2 - g1, 3);
    xact(1'b1, 1'b1, 13'd30, 18'd7, '0, g1);
    xact(1'b1, 1'b0, 13'd30, '0, 18'd7, g1);
    xact(1'b1, 1'b1, 13'd40, 18'd11, '0, g1);
    xact(1'b1, 1'b1, 13'd41, 18'd12, '0, g2);
    chk("write_spacing", g2 - g1, 2);
    repeat (4) @(negedge clk);
    chk("if_rdata_held", {14'd0, if_rdata}, 32'h08014);

    // Reset while the fetch read sits in CAPTURE: no rvalid, everything cleared.
    xact(1'b0, 1'b0, 13'd20, '0, '0, g1);
    void'(sb.pop_back());
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cap_strobes", {mem_re, mem_we, if_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cap_outputs", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_re, mem_we}, 32'd0);
    chk("rst_cap_data", {if_rdata, d_rdata}, 32'd0);
    chk("rst_cap_addr", {19'd0, mem_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Both ports held: first contest after reset goes to data, then alternate.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 13'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 13'd20;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (if_gnt || d_gnt) got = 1'b1;
      end
      chk("contest_gnt_seen", {31'd0, got}, 32'd1);
      chk("contest_one_gnt", {31'd0, if_gnt & d_gnt}, 32'd0);
      chk("contest_winner", {31'd0, d_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (got) sb.push_back('{d_gnt, d_gnt ? 18'd42 : 18'h08014, cyc + 3});
    end
    @(posedge clk); #1 if_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clk);

    // Reset while a read is in ISSUE: the read strobe must already be gone.
    @(posedge clk); #1 d_req = 1'b1; d_addr = 13'd21; d_we = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (d_gnt) got = 1'b1;
    end
    chk("issue_rst_gnt", {31'd0, got}, 32'd1);
    @(posedge clk); #1 d_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("issue_rst_re", {31'd0, mem_re}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    repeat (8) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
